// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants and multiply/divide FSM encodings for the execute stage.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // op[1:0] matches funct[1:0] of MULT/MULTU/DIV/DIVU: bit1 = divide, bit0 = unsigned
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit with the HI/LO register pair.
module ex_muldiv
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output md_state_t   state
);

  md_state_t   state_next;
  logic [4:0]  cnt;
  logic [63:0] p;
  logic [31:0] mag_b;
  logic [31:0] a_raw;
  logic        sign_a;
  logic        sign_b;
  logic        is_div;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        signed_op;

  assign signed_op = ~op[0];

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      MD_IDLE: if (start) begin
        state_next = MD_RUN;
        busy       = 1'b1;
      end
      MD_RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_next = MD_FIX;
      end
      MD_FIX: begin
        busy       = 1'b1;
        state_next = MD_DONE;
      end
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // p holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, p[63:32]} + (p[0] ? {1'b0, mag_b} : 33'd0);
    mul_next  = {mul_sum, p[31:1]};
    div_shift = {p[63:32], p[31]};
    div_trial = div_shift - {1'b0, mag_b};
    div_next  = div_trial[32] ? {div_shift[31:0], p[30:0], 1'b0}
                              : {div_trial[31:0], p[30:0], 1'b1};
    prod_fix  = (sign_a ^ sign_b) ? (~p + 64'd1) : p;
    q_fix     = (sign_a ^ sign_b) ? (~p[31:0] + 32'd1) : p[31:0];
    r_fix     = sign_a ? (~p[63:32] + 32'd1) : p[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= MD_IDLE;
      cnt    <= 5'd0;
      p      <= 64'd0;
      mag_b  <= 32'd0;
      a_raw  <= 32'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        MD_IDLE: begin
          if (start) begin
            p      <= {32'd0, abs_if(a, signed_op)};
            mag_b  <= abs_if(b, signed_op);
            a_raw  <= a;
            sign_a <= signed_op & a[31];
            sign_b <= signed_op & b[31];
            is_div <= op[1];
            cnt    <= 5'd0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        MD_RUN: begin
          p   <= is_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
        end
        MD_FIX: begin
          if (!is_div) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (mag_b == 32'd0) begin
            hi <= a_raw;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU and branch unit around the iterative mul/div unit.
module ex_stage
  import mips_defs::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [31:0] Ed32,
  input  logic [31:0] nextPC,
  output logic [31:0] Result,
  output logic        BrTaken,
  output logic [31:0] BrTarget,
  output logic        Stall
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        is_r;
  logic        is_muldiv;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu;
  logic        eq;
  md_state_t   unused_md_state;
  logic [9:0]  unused_regfields;

  assign opcode           = Ins[31:26];
  assign funct            = Ins[5:0];
  assign shamt            = Ins[10:6];
  assign imm              = Ins[15:0];
  assign unused_regfields = Ins[25:16];
  assign is_r             = (opcode == OP_RTYPE);
  assign is_muldiv        = is_r && (funct[5:2] == 4'b0110);
  assign eq               = (Rdata1 == Rdata2);

  ex_muldiv u_muldiv (
    .clk   (CLK),
    .rst   (RST),
    .start (Valid & is_muldiv),
    .op    (funct[1:0]),
    .a     (Rdata1),
    .b     (Rdata2),
    .mthi  (Valid & is_r & (funct == FN_MTHI)),
    .mtlo  (Valid & is_r & (funct == FN_MTLO)),
    .wdata (Rdata1),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo),
    .state (unused_md_state)
  );

  always_comb begin
    alu = 32'd0;
    if (is_r) begin
      case (funct)
        FN_ADD, FN_ADDU: alu = Rdata1 + Rdata2;
        FN_SUB, FN_SUBU: alu = Rdata1 - Rdata2;
        FN_AND:          alu = Rdata1 & Rdata2;
        FN_OR:           alu = Rdata1 | Rdata2;
        FN_XOR:          alu = Rdata1 ^ Rdata2;
        FN_NOR:          alu = ~(Rdata1 | Rdata2);
        FN_SLT:          alu = {31'd0, $signed(Rdata1) < $signed(Rdata2)};
        FN_SLTU:         alu = {31'd0, Rdata1 < Rdata2};
        FN_SLL:          alu = Rdata2 << shamt;
        FN_SRL:          alu = Rdata2 >> shamt;
        FN_SRA:          alu = $signed(Rdata2) >>> shamt;
        FN_MFHI:         alu = hi;
        FN_MFLO:         alu = lo;
        default:         alu = 32'd0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU: alu = Rdata1 + Ed32;
        OP_SLTI:           alu = {31'd0, $signed(Rdata1) < $signed(Ed32)};
        OP_ANDI:           alu = Rdata1 & {16'd0, imm};
        OP_ORI:            alu = Rdata1 | {16'd0, imm};
        OP_LUI:            alu = {imm, 16'd0};
        default:           alu = 32'd0;
      endcase
    end
  end

  // Every output is held at zero while reset is asserted
  assign Result   = RST ? alu : 32'd0;
  assign BrTaken  = RST & Valid & (((opcode == OP_BEQ) & eq) | ((opcode == OP_BNE) & ~eq));
  assign BrTarget = RST ? (nextPC + {Ed32[29:0], 2'b00}) : 32'd0;
  assign Stall    = RST & md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU, branch, HI/LO moves, mul/div timing and reset abort.
module tb_ex_stage;
  import mips_defs::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Valid = 1'b0;
  logic [31:0] Ins = '0, Rdata1 = '0, Rdata2 = '0, Ed32 = '0, nextPC = '0;
  logic [31:0] Result, BrTarget;
  logic        BrTaken, Stall;
  int          checks = 0;
  int          failures = 0;

  ex_stage dut (
    .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins), .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Ed32(Ed32), .nextPC(nextPC), .Result(Result), .BrTaken(BrTaken),
    .BrTarget(BrTarget), .Stall(Stall)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 10'h000, 5'h00, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] im);
    return {op, 10'h000, im};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] ed, input logic [31:0] npc);
    Valid = v; Ins = ins; Rdata1 = r1; Rdata2 = r2; Ed32 = ed; nextPC = npc;
    #1;
  endtask

  // Issues a mul/div and walks cycles 0..34, reporting stall-high count and Stall on cycle 34
  task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output int stall_hi, output logic stall_last);
    drive(1'b1, rtype(fn, 5'd0), a, b, 32'd0, 32'd0);
    stall_hi = Stall ? 1 : 0;
    stall_last = Stall;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (Stall) stall_hi++;
      stall_last = Stall;
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    drive(1'b1, rtype(FN_MFHI, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
    h = Result;
    drive(1'b1, rtype(FN_MFLO, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
    l = Result;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    RST = 1'b0;
    drive(1'b1, rtype(FN_ADDU, 5'd0), 32'd5, 32'd7, 32'd4, 32'h100);
    tick();
    checks++; if (Result !== 32'd0) begin failures++; $display("FAIL rst_result got=%h exp=%h", Result, 32'd0); end
    checks++; if (BrTarget !== 32'd0) begin failures++; $display("FAIL rst_brtarget got=%h exp=%h", BrTarget, 32'd0); end
    drive(1'b1, rtype(FN_MULT, 5'd0), 32'd3, 32'd4, 32'd0, 32'd0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", Stall); end
    tick();
    Valid = 1'b0;
    RST = 1'b1;
    #1;
    read_hilo(h, l);
    checks++; if (h !== 32'd0 || l !== 32'd0) begin failures++; $display("FAIL rst_hilo got=%h_%h exp=0_0", h, l); end
  endtask

  task automatic test_alu();
    drive(1'b1, rtype(FN_ADDU, 5'd0), 32'd5, 32'd7, 32'd0, 32'd0);
    checks++; if (Result !== 32'd12 || Stall !== 1'b0) begin failures++; $display("FAIL addu got=%h stall=%b exp=0000000c stall=0", Result, Stall); end
    drive(1'b1, rtype(FN_SUB, 5'd0), 32'd3, 32'd5, 32'd0, 32'd0);
    checks++; if (Result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub got=%h exp=fffffffe", Result); end
    drive(1'b1, rtype(FN_SLT, 5'd0), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    checks++; if (Result !== 32'd1) begin failures++; $display("FAIL slt got=%h exp=1", Result); end
    drive(1'b1, rtype(FN_SLTU, 5'd0), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    checks++; if (Result !== 32'd0) begin failures++; $display("FAIL sltu got=%h exp=0", Result); end
    drive(1'b1, rtype(FN_SRA, 5'd4), 32'd0, 32'h8000_0000, 32'd0, 32'd0);
    checks++; if (Result !== 32'hF800_0000) begin failures++; $display("FAIL sra got=%h exp=f8000000", Result); end
    drive(1'b1, rtype(FN_NOR, 5'd0), 32'h0F0F_0000, 32'h0000_00F0, 32'd0, 32'd0);
    checks++; if (Result !== 32'hF0F0_FF0F) begin failures++; $display("FAIL nor got=%h exp=f0f0ff0f", Result); end
    drive(1'b1, itype(OP_LUI, 16'hBEEF), 32'd0, 32'd0, 32'hFFFF_BEEF, 32'd0);
    checks++; if (Result !== 32'hBEEF_0000) begin failures++; $display("FAIL lui got=%h exp=beef0000", Result); end
    drive(1'b1, itype(OP_ORI, 16'h8001), 32'h1200_0000, 32'd0, 32'hFFFF_8001, 32'd0);
    checks++; if (Result !== 32'h1200_8001) begin failures++; $display("FAIL ori got=%h exp=12008001", Result); end
    drive(1'b1, itype(OP_ADDI, 16'hFFFC), 32'd10, 32'd0, 32'hFFFF_FFFC, 32'd0);
    checks++; if (Result !== 32'd6) begin failures++; $display("FAIL addi got=%h exp=6", Result); end
    drive(1'b1, rtype(6'h3F, 5'd0), 32'd9, 32'd9, 32'd0, 32'd0);
    checks++; if (Result !== 32'd0) begin failures++; $display("FAIL undef got=%h exp=0", Result); end
  endtask

  task automatic test_branch();
    drive(1'b1, itype(OP_BEQ, 16'hFFFE), 32'd42, 32'd42, 32'hFFFF_FFFE, 32'h104);
    checks++; if (BrTaken !== 1'b1 || BrTarget !== 32'h0FC) begin failures++; $display("FAIL beq_taken got=%b/%h exp=1/000000fc", BrTaken, BrTarget); end
    checks++; if (Result !== 32'd0) begin failures++; $display("FAIL beq_result got=%h exp=0", Result); end
    drive(1'b0, itype(OP_BEQ, 16'hFFFE), 32'd42, 32'd42, 32'hFFFF_FFFE, 32'h104);
    checks++; if (BrTaken !== 1'b0 || BrTarget !== 32'h0FC) begin failures++; $display("FAIL beq_invalid got=%b/%h exp=0/000000fc", BrTaken, BrTarget); end
    drive(1'b1, itype(OP_BNE, 16'h0010), 32'd1, 32'd2, 32'h0000_0010, 32'h200);
    checks++; if (BrTaken !== 1'b1 || BrTarget !== 32'h240) begin failures++; $display("FAIL bne_taken got=%b/%h exp=1/00000240", BrTaken, BrTarget); end
    drive(1'b1, itype(OP_BNE, 16'h0010), 32'd2, 32'd2, 32'h0000_0010, 32'h200);
    checks++; if (BrTaken !== 1'b0) begin failures++; $display("FAIL bne_equal got=%b exp=0", BrTaken); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h, l;
    drive(1'b1, rtype(FN_MTHI, 5'd0), 32'hCAFE_F00D, 32'd0, 32'd0, 32'd0);
    checks++; if (Result !== 32'd0 || Stall !== 1'b0) begin failures++; $display("FAIL mthi_out got=%h stall=%b exp=0 stall=0", Result, Stall); end
    tick();
    drive(1'b1, rtype(FN_MTLO, 5'd0), 32'h1234_5678, 32'd0, 32'd0, 32'd0);
    tick();
    read_hilo(h, l);
    checks++; if (h !== 32'hCAFE_F00D || l !== 32'h1234_5678) begin failures++; $display("FAIL mthi_mtlo got=%h_%h exp=cafef00d_12345678", h, l); end
  endtask

  task automatic test_invalid_muldiv();
    drive(1'b0, rtype(FN_MULT, 5'd0), 32'd3, 32'd4, 32'd0, 32'd0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL nostart_stall0 got=%b exp=0", Stall); end
    tick();
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL nostart_stall1 got=%b exp=0", Stall); end
  endtask

  task automatic test_mult();
    int s; logic last; logic [31:0] h, l;
    run_md(FN_MULT, 32'hFFFF_FFFD, 32'd7, s, last);
    checks++; if (s !== 34) begin failures++; $display("FAIL mult_stall_cycles got=%0d exp=34", s); end
    checks++; if (last !== 1'b0) begin failures++; $display("FAIL mult_stall_c34 got=%b exp=0", last); end
    read_hilo(h, l);
    checks++; if (l !== 32'hFFFF_FFEB || h !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hilo got=%h_%h exp=ffffffff_ffffffeb", h, l); end
    run_md(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, last);
    read_hilo(h, l);
    checks++; if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin failures++; $display("FAIL multu_hilo got=%h_%h exp=fffffffe_00000001", h, l); end
  endtask

  task automatic test_div();
    int s; logic last; logic [31:0] h, l;
    run_md(FN_DIV, 32'hFFFF_FFF9, 32'd2, s, last);
    read_hilo(h, l);
    checks++; if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", h, l); end
    run_md(FN_DIVU, 32'd7, 32'd0, s, last);
    checks++; if (s !== 34 || last !== 1'b0) begin failures++; $display("FAIL divz_timing got=%0d/%b exp=34/0", s, last); end
    read_hilo(h, l);
    checks++; if (h !== 32'd7 || l !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_zero got=%h_%h exp=00000007_ffffffff", h, l); end
    run_md(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s, last);
    read_hilo(h, l);
    checks++; if (l !== 32'h8000_0000 || h !== 32'd0) begin failures++; $display("FAIL div_min got=%h_%h exp=00000000_80000000", h, l); end
    run_md(FN_DIVU, 32'd100, 32'd7, s, last);
    read_hilo(h, l);
    checks++; if (l !== 32'd14 || h !== 32'd2) begin failures++; $display("FAIL divu_100_7 got=%h_%h exp=00000002_0000000e", h, l); end
  endtask

  task automatic test_reset_mid_op();
    int s; logic last; logic [31:0] h, l;
    drive(1'b1, rtype(FN_DIVU, 5'd0), 32'd100, 32'd7, 32'd0, 32'd0);
    for (int c = 1; c <= 11; c++) tick();
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL midop_running got=%b exp=1", Stall); end
    RST = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL midop_rst_stall got=%b exp=0", Stall); end
    tick();
    checks++; if (Stall !== 1'b0 || Result !== 32'd0) begin failures++; $display("FAIL midop_rst_hold got=%b/%h exp=0/0", Stall, Result); end
    Valid = 1'b0;
    RST = 1'b1;
    #1;
    read_hilo(h, l);
    checks++; if (h !== 32'd0 || l !== 32'd0) begin failures++; $display("FAIL midop_hilo got=%h_%h exp=0_0", h, l); end
    run_md(FN_MULTU, 32'd2, 32'd3, s, last);
    checks++; if (s !== 34 || last !== 1'b0) begin failures++; $display("FAIL midop_retry_timing got=%0d/%b exp=34/0", s, last); end
    read_hilo(h, l);
    checks++; if (l !== 32'd6 || h !== 32'd0) begin failures++; $display("FAIL midop_retry got=%h_%h exp=00000000_00000006", h, l); end
  endtask

  task automatic test_back_to_back();
    int s; logic last; logic [31:0] h, l;
    run_md(FN_MULT, 32'd5, 32'hFFFF_FFFE, s, last);
    tick();
    run_md(FN_DIV, 32'd9, 32'hFFFF_FFFC, s, last);
    read_hilo(h, l);
    checks++; if (l !== 32'hFFFF_FFFE || h !== 32'd1) begin failures++; $display("FAIL b2b_div got=%h_%h exp=00000001_fffffffe", h, l); end
  endtask

  initial begin
    #2;
    test_reset();
    test_alu();
    test_branch();
    test_mthi_mtlo();
    test_invalid_muldiv();
    test_mult();
    test_div();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
